// File: rtl/uart_rx_parity_checker.sv
// uart_rx_parity_checker: oversampled UART receiver with parity and stop-bit framing checks
module uart_rx_parity_checker #(
  parameter int DWIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              rx,
  input  logic              PARITYEN,
  input  logic              PARITYSEL,
  output logic [DWIDTH-1:0] data_out,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);
  localparam int TW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = DWIDTH > 1 ? $clog2(DWIDTH) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DWIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state;
  logic [1:0] sync;
  logic rx_s;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [DWIDTH-1:0] sh;
  logic p, sel_l, en_l, perr;
  assign rx_s = sync[1];
  assign perr = en_l & ((^{p, sh}) != sel_l);
  assign busy = state != IDLE;
  // two-flop synchroniser for the asynchronous line, idling high
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], rx};
  // frame state machine; all sampling happens on baud ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tcnt <= '0;
      bcnt <= '0;
      sh <= '0;
      p <= 1'b0;
      sel_l <= 1'b0;
      en_l <= 1'b0;
      data_out <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (baud_tick) begin
        case (state)
          IDLE: if (!rx_s) begin
            state <= START;
            tcnt <= '0;
          end
          START: if (tcnt == T_HALF) begin
            tcnt <= '0;
            bcnt <= '0;
            state <= rx_s ? IDLE : DATA;
            sel_l <= PARITYSEL;
            en_l <= PARITYEN;
          end else tcnt <= tcnt + 1'b1;
          DATA: if (tcnt == T_LAST) begin
            tcnt <= '0;
            sh[bcnt] <= rx_s;
            bcnt <= bcnt == B_LAST ? '0 : bcnt + 1'b1;
            if (bcnt == B_LAST) state <= en_l ? PARITY : STOP;
          end else tcnt <= tcnt + 1'b1;
          PARITY: if (tcnt == T_LAST) begin
            tcnt <= '0;
            p <= rx_s;
            state <= STOP;
          end else tcnt <= tcnt + 1'b1;
          STOP: if (tcnt == T_LAST) begin
            tcnt <= '0;
            data_out <= sh;
            parity_err <= perr;
            frame_err <= ~rx_s;
            rx_valid <= 1'b1;
            state <= rx_s ? IDLE : BREAK;
          end else tcnt <= tcnt + 1'b1;
          BREAK: if (rx_s) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_parity_checker.sv
// tb_uart_rx_parity_checker: directed frame tests for the UART receiver
module tb_uart_rx_parity_checker;
  logic clk, rst, baud_tick, rx, PARITYEN, PARITYSEL;
  logic [7:0] data_out;
  logic rx_valid, parity_err, frame_err, busy;
  int checks = 0, failures = 0;
  int vcount = 0, v0;
  logic [7:0] cap_d = '0;
  logic cap_pe = 1'b0, cap_fe = 1'b0;

  uart_rx_parity_checker #(.DWIDTH(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
    .PARITYEN(PARITYEN), .PARITYSEL(PARITYSEL), .data_out(data_out),
    .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 0;
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1;
      @(negedge clk);
      baud_tick = 0;
    end
  end

  always @(negedge clk)
    if (rx_valid) begin
      vcount++;
      cap_d = data_out;
      cap_pe = parity_err;
      cap_fe = frame_err;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic p, input logic stop);
    rx = 0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      ticks(16);
    end
    if (par) begin
      rx = p;
      ticks(16);
    end
    rx = stop;
    ticks(16);
    rx = 1;
  endtask

  initial begin
    rst = 1; rx = 1; PARITYEN = 0; PARITYSEL = 0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 0;
    ticks(20);
    // plain 8N1 frame
    v0 = vcount;
    send(8'hA5, 0, 0, 1);
    ticks(8);
    chk("t1_count", 32'(vcount - v0), 1);
    chk("t1_data", 32'(cap_d), 32'hA5);
    chk("t1_perr", 32'(cap_pe), 0);
    chk("t1_ferr", 32'(cap_fe), 0);
    chk("t1_busy", 32'(busy), 0);
    // even parity
    PARITYEN = 1; PARITYSEL = 0;
    send(8'hA5, 1, 0, 1);
    ticks(8);
    chk("t2_even_ok", 32'(cap_pe), 0);
    send(8'hA5, 1, 1, 1);
    ticks(8);
    chk("t2_even_bad", 32'(cap_pe), 1);
    chk("t2_data", 32'(cap_d), 32'hA5);
    // odd parity
    PARITYSEL = 1;
    send(8'h01, 1, 0, 1);
    ticks(8);
    chk("t3_odd_ok", 32'(cap_pe), 0);
    chk("t3_data01", 32'(cap_d), 32'h01);
    send(8'h03, 1, 0, 1);
    ticks(8);
    chk("t3_odd_bad", 32'(cap_pe), 1);
    chk("t3_data03", 32'(cap_d), 32'h03);
    // quarter-bit glitch is rejected at the start-bit midpoint
    v0 = vcount;
    rx = 0;
    ticks(4);
    rx = 1;
    chk("t4_busy_hi", 32'(busy), 1);
    ticks(16);
    chk("t4_busy_lo", 32'(busy), 0);
    chk("t4_count", 32'(vcount - v0), 0);
    // framing error followed by a held break
    PARITYEN = 0;
    v0 = vcount;
    send(8'h3C, 0, 0, 0);
    rx = 0;
    ticks(32);
    chk("t5_count", 32'(vcount - v0), 1);
    chk("t5_ferr", 32'(cap_fe), 1);
    chk("t5_data", 32'(cap_d), 32'h3C);
    chk("t5_break", 32'(busy), 1);
    rx = 1;
    ticks(16);
    chk("t5_idle", 32'(busy), 0);
    send(8'hC3, 0, 0, 1);
    ticks(8);
    chk("t5_count2", 32'(vcount - v0), 2);
    chk("t5_data2", 32'(cap_d), 32'hC3);
    chk("t5_ferr2", 32'(cap_fe), 0);
    // reset in the middle of the data bits
    v0 = vcount;
    rx = 0;
    ticks(40);
    chk("t6_busy_pre", 32'(busy), 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("t6_rst_data", 32'(data_out), 0);
    chk("t6_rst_valid", 32'(rx_valid), 0);
    chk("t6_rst_ferr", 32'(frame_err), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    rx = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    ticks(20);
    chk("t6_no_valid", 32'(vcount - v0), 0);
    send(8'h5A, 0, 0, 1);
    ticks(8);
    chk("t6_count", 32'(vcount - v0), 1);
    chk("t6_data", 32'(cap_d), 32'h5A);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_parity_checker.md
Name: uart_rx_parity_checker

Overview:
Serial receive end of the AHB UART. It deserialises an asynchronous RX line into DWIDTH-bit words using an oversampling baud tick. It checks the optional parity bit with the same polarity convention as the transmit-side parity generator: PARITYSEL=1 selects odd parity, PARITYSEL=0 selects even. It also flags stop-bit framing errors. Received words and their status go to the AHB register/FIFO layer as a one-cycle valid pulse.

Parameters:
DWIDTH, 8, data bits per frame (LSB first).
OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and at least 4.

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-high.
baud_tick  input  1  single-clk pulse at OVERSAMPLE x baud rate.
rx  input  1  serial line, asynchronous, idle high.
PARITYEN  input  1  1 = frame carries a parity bit after the data bits.
PARITYSEL  input  1  1 = odd parity, 0 = even parity; sampled at the start-bit midpoint.
data_out  output  DWIDTH  last received word.
rx_valid  output  1  one-clk pulse when a frame completes.
parity_err  output  1  parity status of the last frame; valid when rx_valid is high, held until the next frame.
frame_err  output  1  stop bit sampled low on the last frame; valid when rx_valid is high, held until the next frame.
busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: data_out=0, rx_valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, counters=0, synchroniser flops=1.
- Synchroniser: rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s; the synchroniser adds 2 clk of latency.
- State machine: IDLE, START, DATA, PARITY, STOP, BREAK. The tick counter tcnt runs 0..OVERSAMPLE-1 and advances only on baud_tick. The bit counter bcnt runs 0..DWIDTH-1.
- IDLE:
  - On baud_tick with rx_s=0, go to START with tcnt=0.
  - Without baud_tick, no action.
- START:
  - At tcnt=OVERSAMPLE/2-1 (the midpoint), if rx_s=1 it is a false start: return to IDLE with no rx_valid.
  - Otherwise latch PARITYSEL and PARITYEN, clear tcnt, go to DATA with bcnt=0.
- DATA:
  - Each time tcnt reaches OVERSAMPLE-1, shift rx_s into the shift register at bit bcnt (LSB first) and clear tcnt.
  - After bit DWIDTH-1 is captured, go to PARITY if the latched PARITYEN=1, otherwise go to STOP.
- PARITY: at tcnt=OVERSAMPLE-1, capture the parity bit p and go to STOP.
- Parity rule: perr = (^{p, shift_reg}) != latched PARITYSEL. With PARITYEN=0, perr=0.
- STOP, at tcnt=OVERSAMPLE-1 (stop-bit midpoint):
  - On the next clk edge: data_out <= shift_reg, parity_err <= perr, frame_err <= ~rx_s, rx_valid <= 1 for exactly one clk.
  - Next state is IDLE if rx_s=1, BREAK if rx_s=0.
- BREAK: wait for rx_s=1 on a baud_tick, then go to IDLE. No rx_valid is generated during a break.
- Latency: rx_valid rises 1 clk after the baud_tick that samples the stop-bit midpoint.
- Back-to-back frames: a start bit immediately following the stop-bit midpoint is detected with no lost frame.
- PARITYSEL/PARITYEN changes mid-frame do not affect the frame in progress.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded with no rx_valid.
- No flow control: data_out is overwritten by the next frame. The consumer must take it on rx_valid.
- baud_tick held high continuously behaves as OVERSAMPLE=1 per clk; the design stays legal and deterministic.

Test Plan:
1. PARITYEN=0, send 8'hA5 with stop=1 -> exactly one rx_valid, data_out=8'hA5, parity_err=0, frame_err=0, busy back to 0.
2. PARITYEN=1, PARITYSEL=0, send 8'hA5 with p=0 -> parity_err=0. Repeat with p=1 -> parity_err=1, data_out=8'hA5.
3. PARITYEN=1, PARITYSEL=1, send 8'h01 with p=0 -> parity_err=0. Send 8'h03 with p=0 -> parity_err=1.
4. 0.25-bit low glitch on rx while IDLE -> no rx_valid, state returns to IDLE, busy pulses then clears.
5. Send 8'h3C with stop=0 and hold rx low for 3 bit times -> rx_valid with frame_err=1 and data_out=8'h3C. State stays in BREAK until rx rises, then a following 8'hC3 frame is received correctly.
6. Assert rst mid-DATA, then send 8'h5A -> no rx_valid for the aborted frame, all outputs 0 during reset. The next frame gives data_out=8'h5A.
